// File: rtl/rgbw_pkg.sv
// rtl/rgbw_pkg.sv - shared state encodings and frame field indices for rgbw_frame_ctrl
package rgbw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_CHECK   = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam int unsigned FLD_MODE   = 0;
    localparam int unsigned FLD_LINT   = 1;
    localparam int unsigned FLD_COLOR  = 2;
    localparam int unsigned FLD_RED    = 3;
    localparam int unsigned FLD_GREEN  = 4;
    localparam int unsigned FLD_BLUE   = 5;
    localparam int unsigned FLD_WHITE  = 6;
    localparam int unsigned NUM_FIELDS = 7;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/rgbw_frame_ctrl_if.sv
// rtl/rgbw_frame_ctrl_if.sv - byte-receiver input and committed-parameter output bundle
interface rgbw_frame_ctrl_if;

    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       cs;
    logic [7:0] mode_o;
    logic [7:0] lint_o;
    logic [7:0] color_idx_o;
    logic [7:0] red_o;
    logic [7:0] green_o;
    logic [7:0] blue_o;
    logic [7:0] white_o;
    logic       frame_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx_rdy, rx_data, cs,
        input  mode_o, lint_o, color_idx_o, red_o, green_o, blue_o, white_o,
        input  frame_valid, frame_err, busy
    );

    modport slave (
        input  rx_rdy, rx_data, cs,
        output mode_o, lint_o, color_idx_o, red_o, green_o, blue_o, white_o,
        output frame_valid, frame_err, busy
    );

endinterface

// File: rtl/rdy_edge_det.sv
// rtl/rdy_edge_det.sv - turns the SPI byte-ready level into a one-cycle byte strobe
module rdy_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic rdy_i,
    output logic strobe_o
);

    logic rdy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rdy_i;
        end
    end

    assign strobe_o = rdy_i & ~rdy_q;

endmodule

// File: rtl/rgbw_frame_ctrl.sv
// rtl/rgbw_frame_ctrl.sv - RGBW frame sequencer with atomic commit; optional checksum byte via FRAME_CHECKSUM_EN
module rgbw_frame_ctrl
    import rgbw_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_W  = 12,
    parameter int unsigned TIMEOUT_MAX = 4095
) (
    input  logic               clk,
    input  logic               reset,
    rgbw_frame_ctrl_if.slave   bus
);

    localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_MAX);

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
    logic [7:0]             shadow_q [NUM_FIELDS];
    logic [7:0]             out_q    [NUM_FIELDS];
    logic                   frame_valid_q, frame_err_q;
    logic                   shadow_we, commit, err_d;
    logic                   strobe, byte_stb;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]             acc_q, acc_d;
`endif

    rdy_edge_det u_edge (
        .clk      (clk),
        .reset    (reset),
        .rdy_i    (bus.rx_rdy),
        .strobe_o (strobe)
    );

    assign byte_stb = strobe & ~bus.cs;

    // Aborts (cs release, timeout) are tested before the strobe so they win a same-cycle race.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = '0;
        shadow_we = 1'b0;
        commit    = 1'b0;
        err_d     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        acc_d     = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
`ifdef FRAME_CHECKSUM_EN
                acc_d = SYNC_BYTE;
`endif
                if (byte_stb && bus.rx_data == SYNC_BYTE) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD, ST_CHECK: begin
                tmo_d = (tmo_q == TMO_LIMIT) ? tmo_q : tmo_q + 1'b1;
                if (bus.cs) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end else if (byte_stb) begin
                    tmo_d = '0;
                    if (state_q == ST_PAYLOAD) begin
                        shadow_we = 1'b1;
                        idx_d     = idx_q + 3'd1;
`ifdef FRAME_CHECKSUM_EN
                        acc_d     = acc_q ^ bus.rx_data;
                        if (idx_q == 3'(FLD_WHITE)) state_d = ST_CHECK;
`else
                        if (idx_q == 3'(FLD_WHITE)) state_d = ST_COMMIT;
`endif
                    end else begin
`ifdef FRAME_CHECKSUM_EN
                        if (bus.rx_data == acc_q) begin
                            state_d = ST_COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end
`else
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
`endif
                    end
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.cs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            tmo_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            acc_q         <= SYNC_BYTE;
`endif
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i] <= 8'h00;
                out_q[i]    <= 8'h00;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            frame_valid_q <= commit;
            frame_err_q   <= err_d;
`ifdef FRAME_CHECKSUM_EN
            acc_q         <= acc_d;
`endif
            if (shadow_we) shadow_q[idx_q] <= bus.rx_data;
            if (commit) begin
                for (int i = 0; i < NUM_FIELDS; i++) out_q[i] <= shadow_q[i];
            end
        end
    end

    assign bus.mode_o      = out_q[FLD_MODE];
    assign bus.lint_o      = out_q[FLD_LINT];
    assign bus.color_idx_o = out_q[FLD_COLOR];
    assign bus.red_o       = out_q[FLD_RED];
    assign bus.green_o     = out_q[FLD_GREEN];
    assign bus.blue_o      = out_q[FLD_BLUE];
    assign bus.white_o     = out_q[FLD_WHITE];
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rgbw_frame_ctrl.sv
// tb/tb_rgbw_frame_ctrl.sv - randomized scoreboard bench for rgbw_frame_ctrl
module tb_rgbw_frame_ctrl;

`ifdef FRAME_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam logic [7:0] SYNC = 8'hA5;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit          is_err;
        logic [55:0] vals;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];
    logic [55:0] committed = '0;

    rgbw_frame_ctrl_if bus();

    rgbw_frame_ctrl dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] outs();
        return {bus.mode_o, bus.lint_o, bus.color_idx_o, bus.red_o,
                bus.green_o, bus.blue_o, bus.white_o};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input bit is_err, input logic [55:0] v);
        ev_t e;
        e.is_err = is_err;
        e.vals   = v;
        exp_q.push_back(e);
    endtask

    // Reference: scan a cs window as a byte list; first sync opens the frame, the next
    // seven bytes (plus checksum when enabled) complete it, everything after is ignored.
    task automatic predict(input bq_t b);
        int s = -1;
        logic [7:0] x;
        logic [55:0] f;
        for (int i = 0; i < b.size(); i++) if (b[i] == SYNC) begin s = i; break; end
        if (s < 0) return;
        if (b.size() - s - 1 < 7 + CK) begin
            push_ev(1'b1, committed);
            return;
        end
        x = SYNC;
        f = '0;
        for (int i = 0; i < 7; i++) begin
            f = {f[47:0], b[s + 1 + i]};
            x = x ^ b[s + 1 + i];
        end
        if (CK == 1 && b[s + 8] != x) begin
            push_ev(1'b1, committed);
        end else begin
            committed = f;
            push_ev(1'b0, f);
        end
    endtask

    function automatic logic [7:0] cksum(input bq_t b, input int s);
        logic [7:0] x = SYNC;
        for (int i = 1; i <= 7; i++) x = x ^ b[s + i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.rx_rdy = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic run_window(input bq_t b);
        predict(b);
        @(posedge clk); #1;
        bus.cs = 1'b0;
        foreach (b[i]) send_byte(b[i]);
        bus.cs = 1'b1;
        @(posedge clk); #1;
        check("busy_after_cs_release", {63'd0, bus.busy}, 64'd0);
        repeat (2) @(posedge clk);
    endtask

    function automatic bq_t good_frame();
        bq_t b;
        b.push_back(SYNC);
        for (int i = 0; i < 7; i++) b.push_back(8'($urandom));
        if (CK == 1) b.push_back(cksum(b, 0));
        return b;
    endfunction

    // Monitor: every frame_valid / frame_err pulse must match the next expected event.
    always @(negedge clk) begin
        if (rst_n && (bus.frame_valid || bus.frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {62'd0, bus.frame_valid, bus.frame_err}, 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_kind", {63'd0, bus.frame_err}, {63'd0, e.is_err});
                check("event_outputs", {8'd0, outs()}, {8'd0, e.vals});
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t b;
        int  c;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        bus.cs      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {8'd0, outs()}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_valid", {63'd0, bus.frame_valid}, 64'd0);
        check("reset_err", {63'd0, bus.frame_err}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        b = '{8'hA5, 8'h01, 8'h80, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40};
        if (CK == 1) b.push_back(cksum(b, 0));
        run_window(b);
        check("scn1_outputs", {8'd0, outs()}, {8'd0, 56'h01_80_03_10_20_30_40});

        b = good_frame();
        b.push_front(8'h00);
        run_window(b);

        b = '{8'hA5, 8'h11, 8'h22, 8'h33};
        run_window(b);

        b = good_frame();
        for (int i = 0; i < 3; i++) b.push_back(8'($urandom));
        run_window(b);

        // Timeout: A5 plus three bytes, then silence with cs held low.
        push_ev(1'b1, committed);
        @(posedge clk); #1;
        bus.cs = 1'b0;
        send_byte(SYNC);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        c = 0;
        while (!bus.frame_err && c < 4300) begin
            @(posedge clk); #1;
            c++;
        end
        check("timeout_latency_ok", {63'd0, (c >= 4092 && c <= 4095)}, 64'd1);
        b = good_frame();
        b.push_back(8'h5A);
        foreach (b[i]) send_byte(b[i]);
        check("timeout_drain_outputs", {8'd0, outs()}, {8'd0, committed});
        bus.cs = 1'b1;
        repeat (3) @(posedge clk);

        for (int w = 0; w < 40; w++) begin
            int kind = $urandom_range(0, 4);
            b = good_frame();
            case (kind)
                1: for (int j = $urandom_range(1, 3); j > 0; j--)
                       b.push_front(8'($urandom_range(0, 8'hA4)));
                2: begin
                       int keep = $urandom_range(1, 7 + CK);
                       while (b.size() > keep) void'(b.pop_back());
                   end
                3: for (int j = $urandom_range(1, 3); j > 0; j--) b.push_back(8'($urandom));
                4: if (CK == 1) b[8] = b[8] ^ 8'($urandom_range(1, 255));
                default: ;
            endcase
            run_window(b);
        end

        repeat (5) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_outputs", {8'd0, outs()}, {8'd0, committed});

        // Asynchronous reset in the middle of the fourth byte.
        @(posedge clk); #1;
        bus.cs = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(i == 0 ? SYNC : 8'($urandom));
        bus.rx_data = 8'h77;
        bus.rx_rdy  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {8'd0, outs()}, 64'd0);
        check("async_reset_busy", {63'd0, bus.busy}, 64'd0);
        committed   = '0;
        bus.rx_rdy  = 1'b0;
        bus.cs      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_window(good_frame());
        repeat (3) @(posedge clk);
        check("post_reset_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
